lamp_countdown_display: RTL and testbench
=========================================

# lamp_countdown_display

Consumer of the traffic-light controller's six lamp outputs. Decodes each direction's lamp pattern into a phase, reloads a per-direction seconds countdown whenever that direction's phase changes, and drives saturated two-digit BCD values for the roadside countdown displays. Optionally flags unsafe lamp combinations.

## Interface
- TICK_CYCLES, 5000: clk cycles per 1 s tick (same rate as the controller).
- TIME_W, 10: width of the time inputs and remaining-time outputs.

- clk  in  1  system clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- north_red_time_pos / north_green_time_pos / north_yellow_time_pos  in  1 each  north lamp drives
- west_red_time_pos / west_green_time_pos / west_yellow_time_pos  in  1 each  west lamp drives
- north_red_time / north_green_time / north_yellow_time  in  TIME_W each  north phase durations, seconds
- west_red_time / west_green_time / west_yellow_time  in  TIME_W each  west phase durations, seconds
- north_phase, west_phase  out  2  0 OFF, 1 GREEN, 2 YELLOW, 3 RED
- north_remain, west_remain  out  TIME_W  seconds remaining in current phase
- north_tens, north_units, west_tens, west_units  out  4  BCD digits of remain, saturated at 99
- conflict_err  out  1  sticky unsafe-lamp flag

## Operation
- Lamp inputs registered once (lamp_q). Per direction, decode lamp_q: exactly one lamp set gives GREEN, YELLOW or RED. No lamp or more than one lamp gives OFF.
- phase_q holds the last decoded phase. A change is decoded phase != phase_q.
- On a change to GREEN, YELLOW or RED: remain loads the matching *_time input, and phase_q updates.
- On a change to OFF: remain is set to 0.
- Tick: tick_cnt counts 0..TICK_CYCLES-1 and wraps. A tick pulse occurs on the cycle tick_cnt == TICK_CYCLES-1. The counter is free-running and shared by both directions, so it is not restarted by phase changes.
- On a tick with no change: remain decrements, saturating at 0.
- A change in the same cycle as a tick: the load wins and no decrement is applied.
- Time inputs are sampled only at load. Changing them mid-phase has no effect until the next change.
- A loaded value of 0 holds at 0.
- BCD: if remain > 99, digits are 9/9. Otherwise tens = remain/10 and units = remain%10.
- Reset values: all outputs 0, phase_q OFF, tick_cnt 0, lamp_q 0.
- Reset mid-count clears everything at the next edge. The first valid lamp pattern after reset always loads, because phase_q is OFF.

## Timing
- Edge k: lamp inputs change.
- Edge k+1: the new inputs are captured in lamp_q.
- Edge k+2: phase outputs and remain are updated.
- Edge k+3: BCD digits are updated.
- A tick at cycle t makes remain decrement at edge t+1. Digits follow one edge later.
- conflict_err asserts 2 edges after the offending input pattern.

## Configuration
- LAMP_CONFLICT_CHECK_EN defined: conflict_err sets and stays set until rst when any of the following holds on lamp_q:
  - both directions are non-RED (GREEN or YELLOW) at the same time;
  - any direction has more than one lamp set.
- Undefined: conflict_err is tied to 0 and no check logic is built. The port is present in both builds.

## Structure
- Package lamp_pkg holds:
  - the phase encoding typedef (OFF/GREEN/YELLOW/RED);
  - TIME_W default;
  - the BCD saturation limit (99).
- Sub-module lamp_dir_counter, instantiated twice (north, west), contains one direction's decode, phase_q, remain register and BCD conversion. It takes the shared tick pulse.
- The top level holds the input register, tick counter and conflict check.

## Test plan
- Load: after rst, drive north green and west red with north_green_time=5 and west_red_time=8.
  - 2 cycles later: north_phase=1, north_remain=5, west_phase=3, west_remain=8.
  - After the next tick: 4 and 7.
- Saturation: north_green_time=2, hold green for 3 ticks -> remain goes 2, 1, 0, 0.
- Load/tick collision: switch north green to yellow (yellow_time=3) so the change lands on the tick cycle -> remain=3, not 2.
- BCD:
  - west_green_time=37 -> west_tens=3, west_units=7;
  - west_green_time=250 -> west_remain=250, digits 9/9.
- Conflict, LAMP_CONFLICT_CHECK_EN defined: north and west green for 1 cycle -> conflict_err=1, still 1 after 100 cycles, 0 after rst.
- Conflict, macro undefined: the same stimulus leaves conflict_err=0.
- Bad pattern and reset:
  - north red+green together -> north_phase=0, north_remain=0;
  - rst asserted mid-countdown (remain=6) -> all outputs 0 at the next edge, and a reload occurs after the next valid lamp.

Source files
------------

// File: rtl/lamp_pkg.sv
// lamp_pkg: phase encoding, default widths and lamp decode helpers shared by the countdown display
package lamp_pkg;
  typedef enum logic [1:0] {PH_OFF = 2'd0, PH_GREEN = 2'd1, PH_YELLOW = 2'd2, PH_RED = 2'd3} phase_e;
  localparam int TIME_W_DEF = 10;
  localparam int BCD_MAX = 99;
  // Lamp vector order is {red, yellow, green}
  function automatic phase_e decode(input logic [2:0] l);
    return l == 3'b001 ? PH_GREEN : l == 3'b010 ? PH_YELLOW : l == 3'b100 ? PH_RED : PH_OFF;
  endfunction
  function automatic logic multi_lamp(input logic [2:0] l);
    return $countones(l) > 1;
  endfunction
endpackage

// File: rtl/lamp_countdown_display_if.sv
// lamp_countdown_display_if: lamp drives, phase durations and display outputs of the countdown display
interface lamp_countdown_display_if #(parameter int TIME_W = lamp_pkg::TIME_W_DEF);
  logic north_red_time_pos, north_green_time_pos, north_yellow_time_pos;
  logic west_red_time_pos, west_green_time_pos, west_yellow_time_pos;
  logic [TIME_W-1:0] north_red_time, north_green_time, north_yellow_time;
  logic [TIME_W-1:0] west_red_time, west_green_time, west_yellow_time;
  logic [1:0] north_phase, west_phase;
  logic [TIME_W-1:0] north_remain, west_remain;
  logic [3:0] north_tens, north_units, west_tens, west_units;
  logic conflict_err;
  modport master(
    output north_red_time_pos, north_green_time_pos, north_yellow_time_pos,
    output west_red_time_pos, west_green_time_pos, west_yellow_time_pos,
    output north_red_time, north_green_time, north_yellow_time,
    output west_red_time, west_green_time, west_yellow_time,
    input north_phase, west_phase, north_remain, west_remain,
    input north_tens, north_units, west_tens, west_units, conflict_err
  );
  modport slave(
    input north_red_time_pos, north_green_time_pos, north_yellow_time_pos,
    input west_red_time_pos, west_green_time_pos, west_yellow_time_pos,
    input north_red_time, north_green_time, north_yellow_time,
    input west_red_time, west_green_time, west_yellow_time,
    output north_phase, west_phase, north_remain, west_remain,
    output north_tens, north_units, west_tens, west_units, conflict_err
  );
endinterface

// File: rtl/lamp_dir_counter.sv
// lamp_dir_counter: one direction's phase decode, reloading seconds countdown and saturated BCD digits
module lamp_dir_counter import lamp_pkg::*; #(
  parameter int TIME_W = TIME_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              tick,
  input  logic [2:0]        lamp,
  input  logic [TIME_W-1:0] red_time,
  input  logic [TIME_W-1:0] yellow_time,
  input  logic [TIME_W-1:0] green_time,
  output phase_e            phase,
  output logic [TIME_W-1:0] remain,
  output logic [3:0]        tens,
  output logic [3:0]        units
);
  phase_e ph_d, phase_q;
  logic chg;
  logic [TIME_W-1:0] load_val;
  logic [6:0] sat_val;
  assign phase = phase_q;
  always_comb begin
    ph_d = decode(lamp);
    chg = ph_d != phase_q;
    load_val = ph_d == PH_GREEN ? green_time : ph_d == PH_YELLOW ? yellow_time : ph_d == PH_RED ? red_time : '0;
    sat_val = remain > TIME_W'(BCD_MAX) ? 7'(BCD_MAX) : remain[6:0];
  end
  // A phase change takes priority over a coincident tick
  always_ff @(posedge clk) begin
    if (rst) begin
      phase_q <= PH_OFF;
      remain <= '0;
      tens <= '0;
      units <= '0;
    end else begin
      if (chg) begin
        phase_q <= ph_d;
        remain <= load_val;
      end else if (tick && remain != '0) begin
        remain <= remain - TIME_W'(1);
      end
      tens <= 4'(sat_val / 7'd10);
      units <= 4'(sat_val % 7'd10);
    end
  end
endmodule

// File: rtl/lamp_countdown_display.sv
// lamp_countdown_display: registers lamp drives, shares a 1 s tick, counts down per direction; LAMP_CONFLICT_CHECK_EN adds a sticky unsafe-lamp flag
module lamp_countdown_display import lamp_pkg::*; #(
  parameter int TICK_CYCLES = 5000,
  parameter int TIME_W = TIME_W_DEF
) (
  input logic clk,
  input logic rst,
  lamp_countdown_display_if.slave bus
);
  localparam int CW = TICK_CYCLES > 1 ? $clog2(TICK_CYCLES) : 1;
  logic [5:0] lamp_q;
  logic [CW-1:0] tick_cnt;
  logic tick;
  phase_e n_phase, w_phase;
  assign tick = tick_cnt == CW'(TICK_CYCLES - 1);
  always_ff @(posedge clk) begin
    if (rst) begin
      lamp_q <= '0;
      tick_cnt <= '0;
    end else begin
      lamp_q <= {bus.west_red_time_pos, bus.west_yellow_time_pos, bus.west_green_time_pos,
                 bus.north_red_time_pos, bus.north_yellow_time_pos, bus.north_green_time_pos};
      tick_cnt <= tick ? '0 : tick_cnt + CW'(1);
    end
  end
  lamp_dir_counter #(.TIME_W(TIME_W)) u_north (
    .clk(clk), .rst(rst), .tick(tick), .lamp(lamp_q[2:0]),
    .red_time(bus.north_red_time), .yellow_time(bus.north_yellow_time), .green_time(bus.north_green_time),
    .phase(n_phase), .remain(bus.north_remain), .tens(bus.north_tens), .units(bus.north_units)
  );
  lamp_dir_counter #(.TIME_W(TIME_W)) u_west (
    .clk(clk), .rst(rst), .tick(tick), .lamp(lamp_q[5:3]),
    .red_time(bus.west_red_time), .yellow_time(bus.west_yellow_time), .green_time(bus.west_green_time),
    .phase(w_phase), .remain(bus.west_remain), .tens(bus.west_tens), .units(bus.west_units)
  );
  assign bus.north_phase = n_phase;
  assign bus.west_phase = w_phase;
`ifdef LAMP_CONFLICT_CHECK_EN
  logic conflict_q, bad;
  phase_e nd, wd;
  always_comb begin
    nd = decode(lamp_q[2:0]);
    wd = decode(lamp_q[5:3]);
    bad = ((nd == PH_GREEN || nd == PH_YELLOW) && (wd == PH_GREEN || wd == PH_YELLOW)) ||
          multi_lamp(lamp_q[2:0]) || multi_lamp(lamp_q[5:3]);
  end
  always_ff @(posedge clk) conflict_q <= rst ? 1'b0 : conflict_q | bad;
  assign bus.conflict_err = conflict_q;
`else
  assign bus.conflict_err = 1'b0;
`endif
endmodule

// File: tb/tb_lamp_countdown_display.sv
// tb_lamp_countdown_display: directed self-checking bench for lamp_countdown_display with a 10-cycle tick
module tb_lamp_countdown_display;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int cyc = 0;
  int n_cmp = 0;
  int n_bad = 0;
`ifdef LAMP_CONFLICT_CHECK_EN
  localparam bit CONF_EN = 1'b1;
`else
  localparam bit CONF_EN = 1'b0;
`endif
  lamp_countdown_display_if #(.TIME_W(10)) bus();
  lamp_countdown_display #(.TICK_CYCLES(10), .TIME_W(10)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "timeout");
  end

  task automatic clr_in();
    {bus.north_red_time_pos, bus.north_green_time_pos, bus.north_yellow_time_pos} = '0;
    {bus.west_red_time_pos, bus.west_green_time_pos, bus.west_yellow_time_pos} = '0;
    bus.north_red_time = '0; bus.north_green_time = '0; bus.north_yellow_time = '0;
    bus.west_red_time = '0; bus.west_green_time = '0; bus.west_yellow_time = '0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    clr_in();
    @(posedge clk); #1;
    rst = 1'b0;
    cyc = 0;
  endtask

  task automatic go(input int t);
    while (cyc < t) begin
      @(posedge clk); #1;
      cyc++;
    end
  endtask

  task automatic test_reset();
    do_reset();
    if (bus.north_phase !== 2'd0) begin $display("FAIL rst_n_phase got %0d want 0", bus.north_phase); n_bad++; end n_cmp++;
    if (bus.north_remain !== 10'd0) begin $display("FAIL rst_n_remain got %0d want 0", bus.north_remain); n_bad++; end n_cmp++;
    if (bus.west_phase !== 2'd0) begin $display("FAIL rst_w_phase got %0d want 0", bus.west_phase); n_bad++; end n_cmp++;
    if ({bus.north_tens, bus.north_units, bus.west_tens, bus.west_units} !== 16'h0) begin $display("FAIL rst_digits got %h want 0000", {bus.north_tens, bus.north_units, bus.west_tens, bus.west_units}); n_bad++; end n_cmp++;
    if (bus.conflict_err !== 1'b0) begin $display("FAIL rst_conflict got %b want 0", bus.conflict_err); n_bad++; end n_cmp++;
  endtask

  task automatic test_load();
    do_reset();
    bus.north_green_time_pos = 1'b1; bus.north_green_time = 10'd5;
    bus.west_red_time_pos = 1'b1; bus.west_red_time = 10'd8;
    go(1);
    if (bus.north_phase !== 2'd0) begin $display("FAIL load_early_phase got %0d want 0", bus.north_phase); n_bad++; end n_cmp++;
    go(2);
    if (bus.north_phase !== 2'd1) begin $display("FAIL load_n_phase got %0d want 1", bus.north_phase); n_bad++; end n_cmp++;
    if (bus.north_remain !== 10'd5) begin $display("FAIL load_n_remain got %0d want 5", bus.north_remain); n_bad++; end n_cmp++;
    if (bus.west_phase !== 2'd3) begin $display("FAIL load_w_phase got %0d want 3", bus.west_phase); n_bad++; end n_cmp++;
    if (bus.west_remain !== 10'd8) begin $display("FAIL load_w_remain got %0d want 8", bus.west_remain); n_bad++; end n_cmp++;
    go(3);
    if ({bus.north_tens, bus.north_units} !== 8'h05) begin $display("FAIL load_n_digits got %h want 05", {bus.north_tens, bus.north_units}); n_bad++; end n_cmp++;
    go(9);
    if (bus.north_remain !== 10'd5) begin $display("FAIL load_pre_tick got %0d want 5", bus.north_remain); n_bad++; end n_cmp++;
    go(10);
    if (bus.north_remain !== 10'd4) begin $display("FAIL tick_n_remain got %0d want 4", bus.north_remain); n_bad++; end n_cmp++;
    if (bus.west_remain !== 10'd7) begin $display("FAIL tick_w_remain got %0d want 7", bus.west_remain); n_bad++; end n_cmp++;
    go(11);
    if ({bus.north_units, bus.west_units} !== 8'h47) begin $display("FAIL tick_units got %h want 47", {bus.north_units, bus.west_units}); n_bad++; end n_cmp++;
  endtask

  task automatic test_saturation();
    do_reset();
    bus.north_green_time_pos = 1'b1; bus.north_green_time = 10'd2;
    go(2);
    if (bus.north_remain !== 10'd2) begin $display("FAIL sat_0 got %0d want 2", bus.north_remain); n_bad++; end n_cmp++;
    go(10);
    if (bus.north_remain !== 10'd1) begin $display("FAIL sat_1 got %0d want 1", bus.north_remain); n_bad++; end n_cmp++;
    go(20);
    if (bus.north_remain !== 10'd0) begin $display("FAIL sat_2 got %0d want 0", bus.north_remain); n_bad++; end n_cmp++;
    go(30);
    if (bus.north_remain !== 10'd0) begin $display("FAIL sat_3 got %0d want 0", bus.north_remain); n_bad++; end n_cmp++;
  endtask

  task automatic test_collision();
    do_reset();
    bus.north_green_time_pos = 1'b1; bus.north_green_time = 10'd5;
    go(8);
    bus.north_green_time_pos = 1'b0; bus.north_yellow_time_pos = 1'b1; bus.north_yellow_time = 10'd3;
    go(9);
    if (bus.north_remain !== 10'd5) begin $display("FAIL coll_before got %0d want 5", bus.north_remain); n_bad++; end n_cmp++;
    go(10);
    if (bus.north_remain !== 10'd3) begin $display("FAIL coll_remain got %0d want 3", bus.north_remain); n_bad++; end n_cmp++;
    if (bus.north_phase !== 2'd2) begin $display("FAIL coll_phase got %0d want 2", bus.north_phase); n_bad++; end n_cmp++;
    go(12);
    bus.north_yellow_time = 10'd9;
    go(20);
    if (bus.north_remain !== 10'd2) begin $display("FAIL midphase_time got %0d want 2", bus.north_remain); n_bad++; end n_cmp++;
  endtask

  task automatic test_bcd();
    do_reset();
    bus.west_green_time_pos = 1'b1; bus.west_green_time = 10'd37;
    go(2);
    if (bus.west_remain !== 10'd37) begin $display("FAIL bcd37_remain got %0d want 37", bus.west_remain); n_bad++; end n_cmp++;
    go(3);
    if ({bus.west_tens, bus.west_units} !== 8'h37) begin $display("FAIL bcd37_digits got %h want 37", {bus.west_tens, bus.west_units}); n_bad++; end n_cmp++;
    bus.west_green_time_pos = 1'b0; bus.west_yellow_time_pos = 1'b1; bus.west_yellow_time = 10'd250;
    go(5);
    if (bus.west_remain !== 10'd250) begin $display("FAIL bcd250_remain got %0d want 250", bus.west_remain); n_bad++; end n_cmp++;
    go(6);
    if ({bus.west_tens, bus.west_units} !== 8'h99) begin $display("FAIL bcd250_digits got %h want 99", {bus.west_tens, bus.west_units}); n_bad++; end n_cmp++;
    bus.west_yellow_time_pos = 1'b0; bus.west_red_time_pos = 1'b1; bus.west_red_time = 10'd100;
    go(8);
    if (bus.west_remain !== 10'd100) begin $display("FAIL bcd100_remain got %0d want 100", bus.west_remain); n_bad++; end n_cmp++;
    go(9);
    if ({bus.west_tens, bus.west_units} !== 8'h99) begin $display("FAIL bcd100_digits got %h want 99", {bus.west_tens, bus.west_units}); n_bad++; end n_cmp++;
    go(21);
    if ({bus.west_tens, bus.west_units} !== 8'h98) begin $display("FAIL bcd98_digits got %h want 98", {bus.west_tens, bus.west_units}); n_bad++; end n_cmp++;
  endtask

  task automatic test_conflict();
    do_reset();
    bus.north_green_time_pos = 1'b1; bus.west_green_time_pos = 1'b1;
    go(1);
    bus.west_green_time_pos = 1'b0; bus.west_red_time_pos = 1'b1;
    go(2);
    if (bus.conflict_err !== CONF_EN) begin $display("FAIL conflict_set got %b want %b", bus.conflict_err, CONF_EN); n_bad++; end n_cmp++;
    go(102);
    if (bus.conflict_err !== CONF_EN) begin $display("FAIL conflict_sticky got %b want %b", bus.conflict_err, CONF_EN); n_bad++; end n_cmp++;
    do_reset();
    if (bus.conflict_err !== 1'b0) begin $display("FAIL conflict_rst got %b want 0", bus.conflict_err); n_bad++; end n_cmp++;
  endtask

  task automatic test_bad_reset();
    do_reset();
    bus.north_red_time_pos = 1'b1; bus.north_green_time_pos = 1'b1;
    bus.north_red_time = 10'd4; bus.north_green_time = 10'd9;
    go(2);
    if (bus.north_phase !== 2'd0) begin $display("FAIL bad_phase got %0d want 0", bus.north_phase); n_bad++; end n_cmp++;
    if (bus.north_remain !== 10'd0) begin $display("FAIL bad_remain got %0d want 0", bus.north_remain); n_bad++; end n_cmp++;
    if (bus.conflict_err !== CONF_EN) begin $display("FAIL bad_conflict got %b want %b", bus.conflict_err, CONF_EN); n_bad++; end n_cmp++;
    bus.north_red_time_pos = 1'b0;
    go(4);
    if (bus.north_remain !== 10'd9) begin $display("FAIL bad_recover got %0d want 9", bus.north_remain); n_bad++; end n_cmp++;
    go(30);
    if (bus.north_remain !== 10'd6) begin $display("FAIL mid_remain got %0d want 6", bus.north_remain); n_bad++; end n_cmp++;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    cyc = 0;
    if (bus.north_remain !== 10'd0) begin $display("FAIL midrst_remain got %0d want 0", bus.north_remain); n_bad++; end n_cmp++;
    if (bus.north_phase !== 2'd0) begin $display("FAIL midrst_phase got %0d want 0", bus.north_phase); n_bad++; end n_cmp++;
    if ({bus.north_tens, bus.north_units} !== 8'h00) begin $display("FAIL midrst_digits got %h want 00", {bus.north_tens, bus.north_units}); n_bad++; end n_cmp++;
    if (bus.conflict_err !== 1'b0) begin $display("FAIL midrst_conflict got %b want 0", bus.conflict_err); n_bad++; end n_cmp++;
    go(2);
    if (bus.north_remain !== 10'd9) begin $display("FAIL reload_remain got %0d want 9", bus.north_remain); n_bad++; end n_cmp++;
    if (bus.north_phase !== 2'd1) begin $display("FAIL reload_phase got %0d want 1", bus.north_phase); n_bad++; end n_cmp++;
  endtask

  initial begin
    clr_in();
    test_reset();
    test_load();
    test_saturation();
    test_collision();
    test_bcd();
    test_conflict();
    test_bad_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
